// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: line count, vector defaults
// and the FSM state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package intr_ctrl_pkg;

  localparam int NUM_LINES = 8;
  localparam int IDX_W     = 3;
  localparam int VEC_W     = 10;

  localparam logic [VEC_W-1:0] VEC_BASE_DEF   = 10'd860;
  localparam logic [VEC_W-1:0] VEC_STRIDE_DEF = 10'd20;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_REQ     = 2'd1;
  localparam state_t ST_SERVICE = 2'd2;

endpackage

// File: rtl/intr_prio_vec.sv
// Lowest-index priority select over the eligible lines, plus that line's vector.
// Latency: combinational. Backpressure: none.
// Ports: eligible (in) -> valid (any set), index (lowest set bit), vector (base + stride*index).
module intr_prio_vec
  import intr_ctrl_pkg::*;
#(
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [VEC_W-1:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic [NUM_LINES-1:0] eligible,
  output logic                 valid,
  output logic [IDX_W-1:0]     index,
  output logic [VEC_W-1:0]     vector
);

  // Scan from the top down so the last hit (the lowest index) wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

  // 10-bit wraparound arithmetic is intentional; no overflow detection.
  assign vector = VEC_BASE + VEC_STRIDE * VEC_W'(index);

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected pending lines, mask, fixed priority, REQ/ack/ret handshake.
// Latency: event on an enabled line in IDLE -> intr_req two clocks later.
// Backpressure: the request is held (vector stable) until intr_ack; further events only accumulate.
// Ports: clk/reset (sync, active-low); intr_in raw lines; mask_we/mask_in mask write;
//        intr_ack/intr_ret CPU handshake; intr_req/intr_dir_out/intr_active/pending_out status.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [VEC_W-1:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] intr_in,
  input  logic                 mask_we,
  input  logic [NUM_LINES-1:0] mask_in,
  input  logic                 intr_ack,
  input  logic                 intr_ret,
  output logic                 intr_req,
  output logic [VEC_W-1:0]     intr_dir_out,
  output logic                 intr_active,
  output logic [NUM_LINES-1:0] pending_out
);

  logic [NUM_LINES-1:0] intr_q;
  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] mask;
  logic [NUM_LINES-1:0] events;
  logic [NUM_LINES-1:0] eligible;
  logic [NUM_LINES-1:0] clr;
  state_t               state;
  logic [IDX_W-1:0]     lat_idx;
  logic [VEC_W-1:0]     lat_vec;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [VEC_W-1:0]     sel_vec;

  // intr_q resets to 0, so lines already high at reset release count as events.
  assign events   = intr_in & ~intr_q;
  assign eligible = pending & mask;

  intr_prio_vec #(
    .VEC_BASE  (VEC_BASE),
    .VEC_STRIDE(VEC_STRIDE)
  ) u_prio (
    .eligible(eligible),
    .valid   (sel_valid),
    .index   (sel_idx),
    .vector  (sel_vec)
  );

  always_comb begin
    clr = '0;
    if (state == ST_REQ && intr_ack) clr[lat_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      intr_q  <= '0;
      pending <= '0;
      mask    <= '0;
      state   <= ST_IDLE;
      lat_idx <= '0;
      lat_vec <= '0;
    end else begin
      intr_q  <= intr_in;
      // Set wins over clear so an event coinciding with its own ack is kept.
      pending <= (pending & ~clr) | events;
      if (mask_we) mask <= mask_in;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            state   <= ST_REQ;
            lat_idx <= sel_idx;
            lat_vec <= sel_vec;
          end
        end
        ST_REQ: begin
          // No preemption: only ack or loss of eligibility leaves REQ.
          if (intr_ack)                 state <= ST_SERVICE;
          else if (!eligible[lat_idx])  state <= ST_IDLE;
        end
        ST_SERVICE: begin
          if (intr_ret) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gated by reset so the CPU-facing outputs are quiet for the whole reset window.
  assign intr_req     = reset && (state == ST_REQ);
  assign intr_active  = reset && (state == ST_SERVICE);
  assign intr_dir_out = (reset && state == ST_REQ) ? lat_vec : '0;
  assign pending_out  = pending;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: table-driven vectors, hand sequences, then randomized run vs a reference model.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] intr_in = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_in = '0;
  logic       intr_ack = 1'b0;
  logic       intr_ret = 1'b0;
  logic       intr_req;
  logic [9:0] intr_dir_out;
  logic       intr_active;
  logic [7:0] pending_out;

  int errors = 0;
  int checks = 0;

  intr_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .intr_in     (intr_in),
    .mask_we     (mask_we),
    .mask_in     (mask_in),
    .intr_ack    (intr_ack),
    .intr_ret    (intr_ret),
    .intr_req    (intr_req),
    .intr_dir_out(intr_dir_out),
    .intr_active (intr_active),
    .pending_out (pending_out)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = requesting, 2 = in service.
  int         m_phase = 0;
  int         m_line  = 0;
  logic [7:0] m_pend  = '0;
  logic [7:0] m_mask  = '0;
  logic [7:0] m_prev  = '0;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    logic [7:0] ev;
    logic [7:0] elig;
    if (!reset) begin
      m_phase = 0; m_line = 0; m_pend = '0; m_mask = '0; m_prev = '0;
    end else begin
      ev     = intr_in & ~m_prev;
      m_prev = intr_in;
      elig   = m_pend & m_mask;
      if (m_phase == 0) begin
        if (elig != 0) begin m_line = lowest(elig); m_phase = 1; end
      end else if (m_phase == 1) begin
        if (intr_ack) begin m_pend[m_line] = 1'b0; m_phase = 2; end
        else if (!elig[m_line]) m_phase = 0;
      end else begin
        if (intr_ret) m_phase = 0;
      end
      m_pend = m_pend | ev;
      if (mask_we) m_mask = mask_in;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk(input string nm, input logic e_req, input logic [9:0] e_dir,
                     input logic e_act, input logic [7:0] e_pend);
    cmp({nm, ".req"},  16'(intr_req),     16'(e_req));
    cmp({nm, ".dir"},  16'(intr_dir_out), 16'(e_dir));
    cmp({nm, ".act"},  16'(intr_active),  16'(e_act));
    cmp({nm, ".pend"}, 16'(pending_out),  16'(e_pend));
  endtask

  typedef struct packed {
    logic       rst;
    logic [7:0] in;
    logic       mwe;
    logic [7:0] mval;
    logic       ack;
    logic       ret;
    logic       e_req;
    logic [9:0] e_dir;
    logic       e_act;
    logic [7:0] e_pend;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [7:0] in, input logic mwe,
                              input logic [7:0] mval, input logic ack, input logic ret,
                              input logic e_req, input logic [9:0] e_dir,
                              input logic e_act, input logic [7:0] e_pend);
    vec_t v;
    v.rst = rst; v.in = in; v.mwe = mwe; v.mval = mval; v.ack = ack; v.ret = ret;
    v.e_req = e_req; v.e_dir = e_dir; v.e_act = e_act; v.e_pend = e_pend;
    return v;
  endfunction

  vec_t tbl[23];

  initial begin
    //             rst in     mwe mval   ack ret  req dir     act pend
    tbl[0]  = mk(0, 8'h00, 0, 8'h00, 0, 0,   0, 10'd0,   0, 8'h00); // reset
    tbl[1]  = mk(0, 8'h00, 0, 8'h00, 0, 0,   0, 10'd0,   0, 8'h00);
    tbl[2]  = mk(1, 8'h00, 1, 8'h01, 0, 0,   0, 10'd0,   0, 8'h00); // mask=01
    tbl[3]  = mk(1, 8'h01, 0, 8'h00, 0, 0,   0, 10'd0,   0, 8'h01); // event line 0
    tbl[4]  = mk(1, 8'h00, 0, 8'h00, 0, 0,   1, 10'd860, 0, 8'h01); // 2 cycles -> req
    tbl[5]  = mk(1, 8'h00, 0, 8'h00, 1, 0,   0, 10'd0,   1, 8'h00); // ack
    tbl[6]  = mk(1, 8'h00, 0, 8'h00, 0, 0,   0, 10'd0,   1, 8'h00);
    tbl[7]  = mk(1, 8'h00, 0, 8'h00, 0, 1,   0, 10'd0,   0, 8'h00); // ret
    tbl[8]  = mk(1, 8'h00, 1, 8'hFF, 0, 0,   0, 10'd0,   0, 8'h00); // mask=FF
    tbl[9]  = mk(1, 8'h28, 0, 8'h00, 0, 0,   0, 10'd0,   0, 8'h28); // lines 3,5
    tbl[10] = mk(1, 8'h00, 0, 8'h00, 0, 0,   1, 10'd920, 0, 8'h28);
    tbl[11] = mk(1, 8'h00, 0, 8'h00, 0, 0,   1, 10'd920, 0, 8'h28); // held
    tbl[12] = mk(1, 8'h00, 0, 8'h00, 1, 0,   0, 10'd0,   1, 8'h20);
    tbl[13] = mk(1, 8'h00, 0, 8'h00, 0, 1,   0, 10'd0,   0, 8'h20);
    tbl[14] = mk(1, 8'h00, 0, 8'h00, 0, 0,   1, 10'd960, 0, 8'h20); // line 5 next
    tbl[15] = mk(1, 8'h00, 0, 8'h00, 1, 0,   0, 10'd0,   1, 8'h00);
    tbl[16] = mk(1, 8'h00, 0, 8'h00, 0, 1,   0, 10'd0,   0, 8'h00);
    tbl[17] = mk(1, 8'h30, 0, 8'h00, 0, 0,   0, 10'd0,   0, 8'h30); // lines 4,5
    tbl[18] = mk(1, 8'h00, 0, 8'h00, 0, 0,   1, 10'd940, 0, 8'h30);
    tbl[19] = mk(1, 8'h10, 0, 8'h00, 1, 0,   0, 10'd0,   1, 8'h30); // event+ack line 4
    tbl[20] = mk(0, 8'h00, 0, 8'h00, 0, 0,   0, 10'd0,   0, 8'h00); // reset in service
    tbl[21] = mk(1, 8'h00, 0, 8'h00, 1, 0,   0, 10'd0,   0, 8'h00); // stray ack
    tbl[22] = mk(1, 8'h00, 0, 8'h00, 0, 1,   0, 10'd0,   0, 8'h00); // stray ret

    @(posedge clk); #1;
    for (int i = 0; i < 23; i++) begin
      reset = tbl[i].rst; intr_in = tbl[i].in; mask_we = tbl[i].mwe;
      mask_in = tbl[i].mval; intr_ack = tbl[i].ack; intr_ret = tbl[i].ret;
      tick();
      chk($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_dir, tbl[i].e_act, tbl[i].e_pend);
    end
    intr_ack = 0; intr_ret = 0; intr_in = 0;

    // No preemption: line 0 arrives while line 5 is requested.
    mask_we = 1; mask_in = 8'hFF; tick(); mask_we = 0;
    intr_in = 8'h20; tick(); intr_in = 8'h00;
    tick();                chk("np_req5",  1, 10'd960, 0, 8'h20);
    intr_in = 8'h01; tick(); chk("np_hold1", 1, 10'd960, 0, 8'h21);
    intr_in = 8'h00; tick(); chk("np_hold2", 1, 10'd960, 0, 8'h21);
    intr_ack = 1; tick(); intr_ack = 0; chk("np_ack", 0, 10'd0, 1, 8'h01);
    intr_ret = 1; tick(); intr_ret = 0; chk("np_ret", 0, 10'd0, 0, 8'h01);
    tick();                chk("np_req0",  1, 10'd860, 0, 8'h01);
    intr_ack = 1; tick(); intr_ack = 0;
    intr_ret = 1; tick(); intr_ret = 0;

    // Withdraw on mask clear, re-request on re-enable.
    intr_in = 8'h04; tick(); intr_in = 8'h00;
    tick();                chk("wd_req2", 1, 10'd900, 0, 8'h04);
    mask_we = 1; mask_in = 8'hFB; tick(); mask_we = 0;
    chk("wd_same", 1, 10'd900, 0, 8'h04);
    tick();                chk("wd_drop", 0, 10'd0, 0, 8'h04);
    tick();                chk("wd_idle", 0, 10'd0, 0, 8'h04);
    mask_we = 1; mask_in = 8'hFF; tick(); mask_we = 0;
    chk("wd_reen", 0, 10'd0, 0, 8'h04);
    tick();                chk("wd_rereq", 1, 10'd900, 0, 8'h04);
    intr_ack = 1; tick(); intr_ack = 0;
    intr_ret = 1; tick(); intr_ret = 0;

    // Event on the acked line in the ack cycle is retained.
    intr_in = 8'h10; tick(); intr_in = 8'h00;
    tick();                chk("ea_req4", 1, 10'd940, 0, 8'h10);
    intr_ack = 1; intr_in = 8'h10; tick(); intr_ack = 0; intr_in = 8'h00;
    chk("ea_keep", 0, 10'd0, 1, 8'h10);
    intr_ret = 1; tick(); intr_ret = 0;
    chk("ea_ret", 0, 10'd0, 0, 8'h10);
    tick();                chk("ea_again", 1, 10'd940, 0, 8'h10);

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) != 0);
      intr_in  = intr_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mask_we  = ($urandom_range(0, 15) == 0);
      mask_in  = 8'($urandom);
      intr_ack = ($urandom_range(0, 2) == 0);
      intr_ret = ($urandom_range(0, 3) == 0);
      tick();
      chk("rand", (m_phase == 1), (m_phase == 1) ? 10'(860 + 20 * m_line) : 10'd0,
          (m_phase == 2), m_pend);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
